clocks_div_gen: RTL and testbench

CLOCKS_DIV_GEN -- requirements
Module: clocks_div_gen

---
 rtl/clocks_div_gen.sv | 139 +++++++++++++
 tb/tb_clocks_div_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clocks_div_gen.sv
// clocks_div_gen: programmable multi-channel clock divider with lock sequencing.
// A single refclk domain drives NUM_CLKS divided clocks. After reset or after a
// new divisor set is accepted, all outputs stay low for LOCK_CYCLES cycles.
// The channels then start together, so every channel shows a rising phase in
// the first locked cycle.
module clocks_div_gen #(
  parameter int unsigned                  NUM_CLKS    = 3,
  parameter int unsigned                  DIV_W       = 8,
  parameter logic [NUM_CLKS*DIV_W-1:0]    DIV_INIT    = {8'd40, 8'd4, 8'd1},
  parameter int unsigned                  LOCK_CYCLES = 16
) (
  input  logic                      refclk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  input  logic [NUM_CLKS*DIV_W-1:0] cfg_div,
  output logic                      cfg_ready,
  output logic [NUM_CLKS-1:0]       outclk,
  output logic [NUM_CLKS-1:0]       outclk_en,
  output logic                      locked
);

  // Lock counter holds 0..LOCK_CYCLES; it parks at LOCK_CYCLES once locked.
  localparam int unsigned    LCW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [LCW-1:0] LOCK_SAT  = LCW'(LOCK_CYCLES);

  typedef enum logic {
    LOCKING = 1'b0,
    LOCKED  = 1'b1
  } state_e;

  state_e                 state_q;
  logic [LCW-1:0]         lock_cnt_q;
  logic [DIV_W-1:0]       div_q       [NUM_CLKS];
  logic [DIV_W-1:0]       cnt_q       [NUM_CLKS];
  logic [NUM_CLKS-1:0]    outclk_q;
  logic [NUM_CLKS-1:0]    outclk_en_q;
  logic                   locked_q;
  logic                   cfg_ready_q;

  // Per-channel next-cycle values while running locked.
  logic [DIV_W-1:0]       div_eff     [NUM_CLKS];
  logic [DIV_W:0]         half_d      [NUM_CLKS];
  logic [DIV_W-1:0]       cnt_d       [NUM_CLKS];
  logic [NUM_CLKS-1:0]    outclk_d;
  logic [NUM_CLKS-1:0]    outclk_en_d;
  logic                   accept;

  // cfg_ready is only high in LOCKED, so acceptance implies the LOCKED state.
  assign accept = cfg_valid & cfg_ready_q;

  // Next counter value per channel and the output levels it implies; outputs
  // are registered from the next count so they line up with the stored count.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CLKS; i++) begin
      div_eff[i]     = (div_q[i] == '0) ? DIV_W'(1) : div_q[i];
      half_d[i]      = ({1'b0, div_eff[i]} + (DIV_W + 1)'(1)) >> 1;
      cnt_d[i]       = (cnt_q[i] == div_eff[i] - DIV_W'(1)) ? '0 : cnt_q[i] + DIV_W'(1);
      outclk_d[i]    = ({1'b0, cnt_d[i]} < half_d[i]);
      outclk_en_d[i] = (cnt_d[i] == '0);
    end
  end

  // Lock FSM, divisor storage, channel counters and all registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= LOCKING;
      lock_cnt_q  <= '0;
      outclk_q    <= '0;
      outclk_en_q <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CLKS; i++) begin
        div_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
        cnt_q[i] <= '0;
      end
    end else begin
      case (state_q)
        LOCKING: begin
          for (int unsigned i = 0; i < NUM_CLKS; i++) begin
            cnt_q[i] <= '0;
          end
          if (lock_cnt_q == LOCK_LAST) begin
            // Entering LOCKED: counters sit at 0, so every channel starts high
            // with its enable strobe in the same cycle.
            state_q     <= LOCKED;
            lock_cnt_q  <= LOCK_SAT;
            outclk_q    <= '1;
            outclk_en_q <= '1;
            locked_q    <= 1'b1;
            cfg_ready_q <= 1'b1;
          end else begin
            lock_cnt_q  <= lock_cnt_q + LCW'(1);
            outclk_q    <= '0;
            outclk_en_q <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
          end
        end
        LOCKED: begin
          if (accept) begin
            state_q     <= LOCKING;
            lock_cnt_q  <= '0;
            outclk_q    <= '0;
            outclk_en_q <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CLKS; i++) begin
              div_q[i] <= cfg_div[i*DIV_W +: DIV_W];
              cnt_q[i] <= '0;
            end
          end else begin
            outclk_q    <= outclk_d;
            outclk_en_q <= outclk_en_d;
            locked_q    <= 1'b1;
            cfg_ready_q <= 1'b1;
            for (int unsigned i = 0; i < NUM_CLKS; i++) begin
              cnt_q[i] <= cnt_d[i];
            end
          end
        end
        default: begin
          state_q     <= LOCKING;
          lock_cnt_q  <= '0;
          outclk_q    <= '0;
          outclk_en_q <= '0;
          locked_q    <= 1'b0;
          cfg_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign outclk    = outclk_q;
  assign outclk_en = outclk_en_q;
  assign locked    = locked_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_clocks_div_gen.sv
// tb_clocks_div_gen: scenario tasks for clocks_div_gen, default and small builds.
module tb_clocks_div_gen;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [23:0] cfg_div;
  logic        cfg_ready;
  logic [2:0]  outclk;
  logic [2:0]  outclk_en;
  logic        locked;

  logic        rst2;
  logic        cfg_valid2;
  logic [3:0]  cfg_div2;
  logic        cfg_ready2;
  logic [0:0]  outclk2;
  logic [0:0]  outclk_en2;
  logic        locked2;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic [3:0] sb2[$];
  logic [7:0] exp_v;
  logic [7:0] obs_v;
  logic [3:0] exp2_v;
  logic [3:0] obs2_v;

  clocks_div_gen dut (
    .refclk    (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .outclk    (outclk),
    .outclk_en (outclk_en),
    .locked    (locked)
  );

  clocks_div_gen #(
    .NUM_CLKS    (1),
    .DIV_W       (4),
    .DIV_INIT    (4'd15),
    .LOCK_CYCLES (1)
  ) dut_small (
    .refclk    (clk),
    .rst       (rst2),
    .cfg_valid (cfg_valid2),
    .cfg_div   (cfg_div2),
    .cfg_ready (cfg_ready2),
    .outclk    (outclk2),
    .outclk_en (outclk_en2),
    .locked    (locked2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {locked, cfg_ready, outclk[2:0], outclk_en[2:0]} k cycles after lock.
  function automatic logic [7:0] lock_vec(int unsigned k, int unsigned d0,
                                          int unsigned d1, int unsigned d2);
    int unsigned d[3];
    logic [2:0]  oc;
    logic [2:0]  en;
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int i = 0; i < 3; i++) begin
      int unsigned dd;
      int unsigned p;
      dd = (d[i] == 0) ? 1 : d[i];
      p = k % dd;
      oc[i] = (p < (dd + 1) / 2);
      en[i] = (p == 0);
    end
    return {2'b11, oc, en};
  endfunction

  function automatic logic [3:0] small_vec(int unsigned k);
    int unsigned p;
    p = k % 15;
    return {2'b11, p < 8, p == 0};
  endfunction

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; cfg_valid = 1'b0; cfg_div = '0;
    cfg_valid2 = 1'b0; cfg_div2 = '0;
    #1;
    sb.push_back(8'h00);
    exp_v = sb.pop_front(); obs_v = {locked, cfg_ready, outclk, outclk_en};
    checks++;
    if (obs_v !== exp_v) begin
      errors++; $display("FAIL reset_async got=%b exp=%b", obs_v, exp_v);
    end
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(8'h00);
    exp_v = sb.pop_front(); obs_v = {locked, cfg_ready, outclk, outclk_en};
    checks++;
    if (obs_v !== exp_v) begin
      errors++; $display("FAIL reset_held got=%b exp=%b", obs_v, exp_v);
    end
    sb2.push_back(4'h0);
    exp2_v = sb2.pop_front(); obs2_v = {locked2, cfg_ready2, outclk2, outclk_en2};
    checks++;
    if (obs2_v !== exp2_v) begin
      errors++; $display("FAIL reset_small got=%b exp=%b", obs2_v, exp2_v);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_defaults();
    for (int j = 0; j < 95; j++) begin
      sb.push_back((j < 15) ? 8'h00 : lock_vec(j - 15, 1, 4, 40));
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = {locked, cfg_ready, outclk, outclk_en};
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL lock_defaults cyc=%0d got=%b exp=%b", j, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_cfg_during_locking();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cfg_div = {8'd7, 8'd2, 8'd9};
    for (int j = 0; j < 60; j++) begin
      cfg_valid = (j <= 15);
      sb.push_back((j < 15) ? 8'h00 : lock_vec(j - 15, 1, 4, 40));
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = {locked, cfg_ready, outclk, outclk_en};
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL cfg_in_locking cyc=%0d got=%b exp=%b", j, obs_v, exp_v);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_cfg_accept();
    cfg_div = {8'd5, 8'd0, 8'd3};
    for (int j = 0; j < 46; j++) begin
      cfg_valid = (j == 0);
      sb.push_back((j < 16) ? 8'h00 : lock_vec(j - 16, 3, 0, 5));
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = {locked, cfg_ready, outclk, outclk_en};
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL cfg_accept cyc=%0d got=%b exp=%b", j, obs_v, exp_v);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    cfg_div = {8'd6, 8'd2, 8'd1};
    cfg_valid = 1'b1;
    for (int j = 0; j < 51; j++) begin
      sb.push_back(((j % 17) == 16) ? lock_vec(0, 1, 2, 6) : 8'h00);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = {locked, cfg_ready, outclk, outclk_en};
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", j, obs_v, exp_v);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int j = 0; j < 6; j++) begin
      sb.push_back(lock_vec(j + 1, 1, 2, 6));
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = {locked, cfg_ready, outclk, outclk_en};
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL pre_rst_run cyc=%0d got=%b exp=%b", j, obs_v, exp_v);
      end
    end
    #3;
    rst = 1'b1;
    #1;
    sb.push_back(8'h00);
    exp_v = sb.pop_front(); obs_v = {locked, cfg_ready, outclk, outclk_en};
    checks++;
    if (obs_v !== exp_v) begin
      errors++; $display("FAIL rst_midcycle got=%b exp=%b", obs_v, exp_v);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 60; j++) begin
      sb.push_back((j < 15) ? 8'h00 : lock_vec(j - 15, 1, 4, 40));
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = {locked, cfg_ready, outclk, outclk_en};
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL post_rst_relock cyc=%0d got=%b exp=%b", j, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_small_build();
    rst2 = 1'b0;
    for (int j = 0; j < 45; j++) begin
      sb2.push_back(small_vec(j));
      @(posedge clk); #1;
      exp2_v = sb2.pop_front(); obs2_v = {locked2, cfg_ready2, outclk2, outclk_en2};
      checks++;
      if (obs2_v !== exp2_v) begin
        errors++; $display("FAIL small_build cyc=%0d got=%b exp=%b", j, obs2_v, exp2_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_defaults();
    test_cfg_during_locking();
    test_cfg_accept();
    test_back_to_back();
    test_async_reset();
    test_small_build();
    if (sb.size() != 0 || sb2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size() + sb2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
